// File: rtl/box_h_stream_fp.sv
// Streaming horizontal box filter: builds a centred TAPS-wide window from a raster pixel
// stream with edge replication, flushes R trailing centres per row, and feeds the FP core.

// Window multiply-accumulate, one registered stage. Every tap uses the same COEF, so the
// window is summed exactly in fixed point and scaled once; the result is truncated, and
// subnormal results are flushed to zero.
module box_h_fp_mac #(
    parameter int unsigned EXP_WIDTH  = 5,
    parameter int unsigned FRAC_WIDTH = 10,
    parameter int unsigned TAPS       = 3,
    parameter logic [EXP_WIDTH+FRAC_WIDTH:0] COEF = 16'h3555
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [TAPS*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] win,
    input  logic                                     win_valid,
    input  logic [15:0]                              win_col,
    input  logic [15:0]                              win_row,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]            data,
    output logic [15:0]                              col,
    output logic [15:0]                              row,
    output logic                                     valid
);
    localparam int unsigned FP_W   = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned MANT_W = FRAC_WIDTH + 1;
    localparam int unsigned EMAX   = (1 << EXP_WIDTH) - 1;
    localparam int unsigned BIAS   = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int unsigned FIX_W  = MANT_W + EMAX - 1;
    localparam int unsigned SUM_W  = FIX_W + $clog2(TAPS) + 1;
    localparam int unsigned PROD_W = SUM_W + MANT_W;

    localparam logic [EXP_WIDTH-1:0] COEF_E  = COEF[FP_W-2 -: EXP_WIDTH];
    localparam int unsigned          COEF_EB = (COEF_E == '0) ? 1 : int'(COEF_E);
    localparam logic [MANT_W-1:0]    COEF_M  = {COEF_E != '0, COEF[FRAC_WIDTH-1:0]};
    localparam logic                 COEF_S  = COEF[FP_W-1];

    // Magnitude to fixed point with LSB weight 2^(1-BIAS-FRAC_WIDTH).
    function automatic logic [FIX_W-1:0] to_fix(input logic [FP_W-2:0] v);
        logic [EXP_WIDTH-1:0] e;
        logic [MANT_W-1:0]    m;
        e = v[FP_W-2 -: EXP_WIDTH];
        m = {e != '0, v[FRAC_WIDTH-1:0]};
        if (e == '0) return FIX_W'(m);
        return FIX_W'(m) << (e - EXP_WIDTH'(1));
    endfunction

    logic [FP_W-1:0]       px;
    logic [SUM_W-1:0]      acc;
    logic [SUM_W-1:0]      mag;
    logic                  neg;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     norm;
    logic [FRAC_WIDTH-1:0] frac;
    logic                  nz;
    int                    lead;
    int                    exp_b;
    logic [FP_W-1:0]       res_c;

    always_comb begin
        px    = '0;
        acc   = '0;
        lead  = 0;
        nz    = 1'b0;
        for (int i = 0; i < int'(TAPS); i++) begin
            px = win[i*FP_W +: FP_W];
            if (px[FP_W-1]) acc = acc - SUM_W'(to_fix(px[FP_W-2:0]));
            else            acc = acc + SUM_W'(to_fix(px[FP_W-2:0]));
        end
        neg  = acc[SUM_W-1];
        mag  = neg ? (~acc + SUM_W'(1)) : acc;
        prod = PROD_W'(mag) * PROD_W'(COEF_M);
        for (int i = 0; i < int'(PROD_W); i++) begin
            if (prod[i]) begin
                lead = i;
                nz   = 1'b1;
            end
        end
        exp_b = lead + 1 + int'(COEF_EB) - int'(BIAS) - 2 * int'(FRAC_WIDTH);
        norm  = prod << (PROD_W - 1 - lead);
        frac  = FRAC_WIDTH'(norm >> (PROD_W - 1 - FRAC_WIDTH));
        if (!nz || exp_b <= 0)        res_c = '0;
        else if (exp_b >= int'(EMAX)) res_c = {COEF_S ^ neg, {EXP_WIDTH{1'b1}}, FRAC_WIDTH'(0)};
        else                          res_c = {COEF_S ^ neg, EXP_WIDTH'(exp_b), frac};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            col   <= '0;
            row   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= win_valid;
            if (win_valid) begin
                data <= res_c;
                col  <= win_col;
                row  <= win_row;
            end
        end
    end
endmodule

module box_h_stream_fp #(
    parameter int unsigned EXP_WIDTH  = 5,
    parameter int unsigned FRAC_WIDTH = 10,
    parameter int unsigned TAPS       = 3,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter logic [EXP_WIDTH+FRAC_WIDTH:0] COEF = 16'h3555
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] pixel_i,
    input  logic [15:0]                   col_i,
    input  logic [15:0]                   row_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] data_o,
    output logic [15:0]                   col_o,
    output logic [15:0]                   row_o,
    output logic                          valid_o
);
    localparam int unsigned FP_W     = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned R        = (TAPS - 1) / 2;
    localparam int unsigned LAST_COL = IMG_WIDTH - 1;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state_q, state_nxt;
    logic [FP_W-1:0]  sr [TAPS];
    logic [15:0]      ctr_q;
    logic [15:0]      row_q;
    logic [CNT_W-1:0] flush_q, flush_nxt;
    logic             win_valid_q;
    logic [15:0]      win_col_q;
    logic [15:0]      win_row_q;
    logic             accept;
    logic             load, shift, flush_shift, issue;
    logic [TAPS*FP_W-1:0] win_flat;
    logic             core_rst;

    assign accept   = valid_i && ready_o;
    assign core_rst = ~rst_i;

    // Next state and datapath controls.
    always_comb begin
        state_nxt   = state_q;
        flush_nxt   = flush_q;
        load        = 1'b0;
        shift       = 1'b0;
        flush_shift = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && col_i == '0) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_i == '0) begin
                        load = 1'b1;
                    end else begin
                        shift = 1'b1;
                        issue = (col_i >= 16'(R));
                        if (col_i == 16'(LAST_COL)) begin
                            state_nxt = FLUSH;
                            flush_nxt = CNT_W'(R);
                        end
                    end
                end
            end
            FLUSH: begin
                flush_shift = 1'b1;
                issue       = 1'b1;
                flush_nxt   = flush_q - CNT_W'(1);
                if (flush_q == CNT_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ready_o     <= 1'b1;
            flush_q     <= '0;
            ctr_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            for (int i = 0; i < int'(TAPS); i++) sr[i] <= '0;
        end else begin
            state_q     <= state_nxt;
            ready_o     <= (state_nxt != FLUSH);
            flush_q     <= flush_nxt;
            win_valid_q <= issue;
            if (load) begin
                for (int i = 0; i < int'(TAPS); i++) sr[i] <= pixel_i;
                row_q <= row_i;
                ctr_q <= '0;
            end else if (shift || flush_shift) begin
                // Flush replicates the right-border pixel.
                for (int i = 0; i < int'(TAPS) - 1; i++) sr[i] <= sr[i+1];
                sr[TAPS-1] <= shift ? pixel_i : sr[TAPS-1];
            end
            if (issue) begin
                win_col_q <= ctr_q;
                win_row_q <= row_q;
                ctr_q     <= (ctr_q == 16'(LAST_COL)) ? '0 : ctr_q + 16'd1;
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < int'(TAPS); i++) win_flat[i*FP_W +: FP_W] = sr[i];
    end

    box_h_fp_mac #(
        .EXP_WIDTH (EXP_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH),
        .TAPS      (TAPS),
        .COEF      (COEF)
    ) u_mac (
        .clk      (clk_i),
        .rst      (core_rst),
        .win      (win_flat),
        .win_valid(win_valid_q),
        .win_col  (win_col_q),
        .win_row  (win_row_q),
        .data     (data_o),
        .col      (col_o),
        .row      (row_o),
        .valid    (valid_o)
    );
endmodule

// File: tb/tb_box_h_stream_fp.sv
// Directed bench for box_h_stream_fp: TAPS=3 and TAPS=5 instances, IMG_WIDTH=5, COEF=1.0.
module tb_box_h_stream_fp;
    localparam int W   = 5;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] p3, c3, r3, d3, co3, ro3;
    logic        v3, rdy3, vo3;
    logic [15:0] p5, c5, r5, d5, co5, ro5;
    logic        v5, rdy5, vo5;

    int cyc  = 0;
    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] c;
        logic [15:0] r;
        int          t;
    } out_t;

    out_t q3[$];
    out_t q5[$];
    int   acc[$];

    logic [15:0] px  [5] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
    logic [15:0] ex3 [5] = '{16'h4400, 16'h4600, 16'h4880, 16'h4A00, 16'h4B00};
    logic [15:0] ex5 [5] = '{16'h4800, 16'h4980, 16'h4B80, 16'h4CC0, 16'h4D80};
    int          gaps[4] = '{0, 2, 1, 3};

    box_h_stream_fp #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .TAPS(3), .IMG_WIDTH(W), .COEF(16'h3C00)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .pixel_i(p3), .col_i(c3), .row_i(r3), .valid_i(v3),
        .ready_o(rdy3), .data_o(d3), .col_o(co3), .row_o(ro3), .valid_o(vo3));

    box_h_stream_fp #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .TAPS(5), .IMG_WIDTH(W), .COEF(16'h3C00)) u_dut5 (
        .clk_i(clk), .rst_i(rst_n), .pixel_i(p5), .col_i(c5), .row_i(r5), .valid_i(v5),
        .ready_o(rdy5), .data_o(d5), .col_o(co5), .row_o(ro5), .valid_o(vo5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vo3) q3.push_back('{d: d3, c: co3, r: ro3, t: cyc});
        if (vo5) q5.push_back('{d: d5, c: co5, r: ro5, t: cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel and hold it until accepted; leaves valid low on the following negedge.
    task automatic send(input int dut, input logic [15:0] p, input int c, input int r);
        int n;
        n = 0;
        if (dut == 5) begin p5 = p; c5 = 16'(c); r5 = 16'(r); v5 = 1'b1; end
        else          begin p3 = p; c3 = 16'(c); r3 = 16'(r); v3 = 1'b1; end
        while (((dut == 5) ? !rdy5 : !rdy3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        acc.push_back(cyc);
        @(negedge clk);
        if (dut == 5) v5 = 1'b0; else v3 = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
        #1;
    endtask

    // Expected output cycle of centre c, given accepts acc[base..base+W-1] of that row.
    function automatic int exp_t(input int c, input int base, input int r);
        if (c + r <= W - 1) return acc[base + c + r] + LAT;
        return acc[base + W - 1] + LAT + (c + r - (W - 1));
    endfunction

    task automatic check_row3(input int first, input int base, input int row);
        for (int c = 0; c < W; c++) begin
            chk("row_data", 32'(q3[first+c].d), 32'(ex3[c]));
            chk("row_col",  32'(q3[first+c].c), 32'(c));
            chk("row_row",  32'(q3[first+c].r), 32'(row));
            chk("row_lat",  32'(q3[first+c].t), 32'(exp_t(c, base, 1)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v3 = 1'b0; p3 = '0; c3 = '0; r3 = '0;
        v5 = 1'b0; p5 = '0; c5 = '0; r5 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(vo3), 32'd0);
        chk("rst_ready", 32'(rdy3), 32'd1);
        chk("rst_data",  32'(d3), 32'd0);
        chk("rst_col",   32'(co3), 32'd0);
        chk("rst_row",   32'(ro3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic row, TAPS=3
        acc.delete(); q3.delete();
        for (int i = 0; i < W; i++) send(3, px[i], i, 7);
        chk("basic_rdy_low", 32'(rdy3), 32'd0);
        @(negedge clk);
        chk("basic_rdy_back", 32'(rdy3), 32'd1);
        settle();
        chk("basic_count", 32'(q3.size()), 32'd5);
        if (q3.size() == 5) check_row3(0, 0, 7);

        // Wide window, TAPS=5
        @(negedge clk);
        acc.delete(); q5.delete();
        for (int i = 0; i < W; i++) send(5, px[i], i, 7);
        chk("wide_rdy_low0", 32'(rdy5), 32'd0);
        @(negedge clk);
        chk("wide_rdy_low1", 32'(rdy5), 32'd0);
        @(negedge clk);
        chk("wide_rdy_back", 32'(rdy5), 32'd1);
        settle();
        chk("wide_count", 32'(q5.size()), 32'd5);
        if (q5.size() == 5) begin
            for (int c = 0; c < W; c++) begin
                chk("wide_data", 32'(q5[c].d), 32'(ex5[c]));
                chk("wide_col",  32'(q5[c].c), 32'(c));
                chk("wide_lat",  32'(q5[c].t), 32'(exp_t(c, 0, 2)));
            end
        end

        // Back-to-back rows: row 8 col 0 is held through the flush
        @(negedge clk);
        acc.delete(); q3.delete();
        for (int i = 0; i < W; i++) send(3, px[i], i, 7);
        for (int i = 0; i < W; i++) send(3, px[i], i, 8);
        settle();
        chk("b2b_hold", 32'(acc[5] - acc[4]), 32'd2);
        chk("b2b_count", 32'(q3.size()), 32'd10);
        if (q3.size() == 10) begin
            check_row3(0, 0, 7);
            check_row3(5, 5, 8);
        end

        // Idle gaps between accepts
        @(negedge clk);
        acc.delete(); q3.delete();
        for (int i = 0; i < W; i++) begin
            send(3, px[i], i, 11);
            if (i < W - 1) repeat (gaps[i]) @(negedge clk);
        end
        settle();
        chk("gap_count", 32'(q3.size()), 32'd5);
        if (q3.size() == 5) check_row3(0, 0, 11);

        // Mid-row restart: row 9 abandoned after col 2
        @(negedge clk);
        acc.delete(); q3.delete();
        for (int i = 0; i < 3; i++) send(3, 16'h4600, i, 9);
        for (int i = 0; i < W; i++) send(3, px[i], i, 10);
        settle();
        chk("restart_count", 32'(q3.size()), 32'd7);
        if (q3.size() == 7) begin
            for (int c = 0; c < 2; c++) begin
                chk("restart_old_data", 32'(q3[c].d), 32'h4C80);
                chk("restart_old_col",  32'(q3[c].c), 32'(c));
                chk("restart_old_row",  32'(q3[c].r), 32'd9);
            end
            check_row3(2, 3, 10);
        end

        // Non-zero column while idle is dropped
        @(negedge clk);
        acc.delete(); q3.delete();
        send(3, 16'h4500, 3, 12);
        settle();
        chk("idle_drop", 32'(q3.size()), 32'd0);

        // Reset during flush
        @(negedge clk);
        acc.delete(); q3.delete();
        for (int i = 0; i < W; i++) send(3, px[i], i, 12);
        chk("pre_rst_flush", 32'(rdy3), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(vo3), 32'd0);
        chk("midrst_ready", 32'(rdy3), 32'd1);
        q3.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        settle();
        chk("midrst_stale", 32'(q3.size()), 32'd0);
        @(negedge clk);
        acc.delete(); q3.delete();
        for (int i = 0; i < W; i++) send(3, px[i], i, 13);
        settle();
        chk("post_rst_count", 32'(q3.size()), 32'd5);
        if (q3.size() == 5) check_row3(0, 0, 13);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
